qnigma_tcp_ack_track: RTL and testbench

Parametrised receive-side acknowledgement tracker for the TCP engine: it keeps the local cumulative ACK number and up to `SACK_BLOCKS` selective-ACK ranges, and decides when a pure ACK must be sent. It sits between the TCP RX header parser (segment descriptors) and the TCP TX engine (ACK request/confirm). It generalises the fixed delayed-ACK/SACK pair with configurable block count, timeout, packet threshold and receive window, plus duplicate-segment detection and iterative block merging.

---
 rtl/qnigma_tcp_ack_track.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_qnigma_tcp_ack_track.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qnigma_tcp_ack_track.sv
// qnigma_tcp_ack_track: receive-side cumulative ACK and SACK tracker with delayed-ACK control.
// Define QNIGMA_TCP_SACK_EN to build the SACK list with its insert and merge engine. Without
// the macro, out-of-order data is treated as duplicate and the SACK outputs read as zero.
module qnigma_tcp_ack_track #(
    parameter int unsigned SACK_BLOCKS    = 4,
    parameter int unsigned ACK_TIMEOUT_MS = 50,
    parameter int unsigned ACK_PKT_THRESH = 2,
    parameter int unsigned RX_WIN         = 65535
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tick_ms,
    input  logic                      ini,
    input  logic [31:0]               ini_ack,
    input  logic                      seg_val,
    output logic                      seg_rdy,
    input  logic [31:0]               seg_seq,
    input  logic [15:0]               seg_len,
    output logic [31:0]               loc_ack,
    output logic [32*SACK_BLOCKS-1:0] sack_left,
    output logic [32*SACK_BLOCKS-1:0] sack_right,
    output logic [2:0]                sack_cnt,
    output logic                      send_ack,
    input  logic                      ack_sent
);

`ifdef QNIGMA_TCP_SACK_EN
    localparam bit SackEn = 1'b1;
`else
    localparam bit SackEn = 1'b0;
`endif
    localparam logic [3:0] PktThresh = 4'(ACK_PKT_THRESH);
    localparam logic [7:0] TmrLimit  = 8'(ACK_TIMEOUT_MS);

    typedef enum logic [1:0] {StIdle, StInsert, StMerge} state_e;

    state_e      state_q, state_d;
    logic [31:0] loc_ack_q, loc_ack_d;
    logic [3:0]  pkt_cnt_q, pkt_cnt_d;
    logic [7:0]  tmr_q, tmr_d;
    logic        send_ack_q, send_ack_d;

    logic [31:0] seg_end, seg_dist, end_gap;
    logic        accept, acc_inorder, acc_dup, acc_ooo;

    // Merge-engine results; tied off when the SACK list is not built.
    logic        mrg_hit;
    logic [31:0] mrg_right;

    // Modulo-2^32 "a is after b".
    function automatic logic seq_after(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] diff;
        diff = a - b;
        return $signed(diff) > 32'sd0;
    endfunction

    assign seg_end     = seg_seq + 32'(seg_len);
    assign seg_dist    = seg_seq - loc_ack_q;
    assign end_gap     = seg_end - loc_ack_q;
    assign accept      = seg_val && (state_q == StIdle) && (seg_len != 16'd0);
    assign acc_inorder = accept && (seg_dist == 32'd0);
    // Segment ends at or before the ACK point: already received.
    assign acc_dup     = accept && (seg_dist != 32'd0) && ($signed(end_gap) <= 32'sd0);
    assign acc_ooo     = accept && (seg_dist != 32'd0) && ($signed(end_gap) > 32'sd0) &&
                         (seg_dist < 32'(RX_WIN));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ini abandons any insert or merge in flight.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (acc_inorder && SackEn) begin
                    state_d = StMerge;
                end else if (acc_ooo && SackEn) begin
                    state_d = StInsert;
                end
            end
            StInsert: state_d = StIdle;
            StMerge: begin
                if (!mrg_hit) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (ini) begin
            state_d = StIdle;
        end
    end

    // FSM outputs.
    always_comb begin
        seg_rdy = (state_q == StIdle);
    end

    // Cumulative ACK, delayed-ACK counters and the pure-ACK request.
    always_comb begin
        loc_ack_d = loc_ack_q;
        pkt_cnt_d = ack_sent ? 4'd0 : pkt_cnt_q;
        tmr_d     = ack_sent ? 8'd0 : tmr_q;
        if (!ack_sent && tick_ms && (pkt_cnt_q != 4'd0) && (tmr_q != TmrLimit)) begin
            tmr_d = tmr_q + 8'd1;
        end
        if (acc_inorder) begin
            loc_ack_d = seg_end;
            if (pkt_cnt_d != 4'hF) begin
                pkt_cnt_d = pkt_cnt_d + 4'd1;
            end
        end
        if ((state_q == StMerge) && mrg_hit && seq_after(mrg_right, loc_ack_q)) begin
            loc_ack_d = mrg_right;
        end
        // A set cause in the same cycle as ack_sent wins.
        send_ack_d = send_ack_q && !ack_sent;
        if (acc_dup || acc_ooo || ((state_q == StMerge) && mrg_hit) ||
            (pkt_cnt_d >= PktThresh) || (tmr_d == TmrLimit)) begin
            send_ack_d = 1'b1;
        end
        if (ini) begin
            loc_ack_d  = ini_ack;
            pkt_cnt_d  = 4'd0;
            tmr_d      = 8'd0;
            send_ack_d = 1'b0;
        end
    end

    // ACK and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            loc_ack_q  <= '0;
            pkt_cnt_q  <= '0;
            tmr_q      <= '0;
            send_ack_q <= 1'b0;
        end else begin
            loc_ack_q  <= loc_ack_d;
            pkt_cnt_q  <= pkt_cnt_d;
            tmr_q      <= tmr_d;
            send_ack_q <= send_ack_d;
        end
    end

    assign loc_ack  = loc_ack_q;
    assign send_ack = send_ack_q;

`ifdef QNIGMA_TCP_SACK_EN
    logic [31:0] left_q  [SACK_BLOCKS];
    logic [31:0] left_d  [SACK_BLOCKS];
    logic [31:0] right_q [SACK_BLOCKS];
    logic [31:0] right_d [SACK_BLOCKS];
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] ins_left_q, ins_right_q;
    logic        ins_hit;
    logic [2:0]  ins_idx, mrg_idx;
    logic [31:0] uni_left, uni_right;

    // Pending out-of-order range, consumed by the INSERT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ins_left_q  <= '0;
            ins_right_q <= '0;
        end else if (acc_ooo) begin
            ins_left_q  <= seg_seq;
            ins_right_q <= seg_end;
        end
    end

    // First entry overlapping or abutting the pending range, and the union of the two.
    always_comb begin
        ins_hit   = 1'b0;
        ins_idx   = '0;
        uni_left  = ins_left_q;
        uni_right = ins_right_q;
        for (int i = 0; i < int'(SACK_BLOCKS); i++) begin
            if (!ins_hit && (3'(i) < cnt_q) && !seq_after(left_q[i], ins_right_q) &&
                !seq_after(ins_left_q, right_q[i])) begin
                ins_hit = 1'b1;
                ins_idx = 3'(i);
                if (seq_after(ins_left_q, left_q[i])) begin
                    uni_left = left_q[i];
                end
                if (seq_after(right_q[i], ins_right_q)) begin
                    uni_right = right_q[i];
                end
            end
        end
    end

    // First entry whose left edge the cumulative ACK has reached; one absorbed per cycle.
    always_comb begin
        mrg_hit   = 1'b0;
        mrg_idx   = '0;
        mrg_right = '0;
        for (int i = 0; i < int'(SACK_BLOCKS); i++) begin
            if (!mrg_hit && (3'(i) < cnt_q) && !seq_after(left_q[i], loc_ack_q)) begin
                mrg_hit   = 1'b1;
                mrg_idx   = 3'(i);
                mrg_right = right_q[i];
            end
        end
    end

    // List update: move-to-front on insert, remove-and-compact on merge.
    always_comb begin
        left_d  = left_q;
        right_d = right_q;
        cnt_d   = cnt_q;
        if (state_q == StInsert) begin
            for (int j = 1; j < int'(SACK_BLOCKS); j++) begin
                if (!ins_hit || (3'(j) <= ins_idx)) begin
                    left_d[j]  = left_q[j-1];
                    right_d[j] = right_q[j-1];
                end
            end
            left_d[0]  = uni_left;
            right_d[0] = uni_right;
            if (!ins_hit && (cnt_q != 3'(SACK_BLOCKS))) begin
                cnt_d = cnt_q + 3'd1;
            end
        end else if ((state_q == StMerge) && mrg_hit) begin
            for (int j = 0; j < int'(SACK_BLOCKS) - 1; j++) begin
                if (3'(j) >= mrg_idx) begin
                    left_d[j]  = left_q[j+1];
                    right_d[j] = right_q[j+1];
                end
            end
            left_d[SACK_BLOCKS-1]  = '0;
            right_d[SACK_BLOCKS-1] = '0;
            cnt_d = cnt_q - 3'd1;
        end
        if (ini) begin
            for (int j = 0; j < int'(SACK_BLOCKS); j++) begin
                left_d[j]  = '0;
                right_d[j] = '0;
            end
            cnt_d = '0;
        end
    end

    // SACK list registers; unused slots are kept at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < int'(SACK_BLOCKS); j++) begin
                left_q[j]  <= '0;
                right_q[j] <= '0;
            end
            cnt_q <= '0;
        end else begin
            left_q  <= left_d;
            right_q <= right_d;
            cnt_q   <= cnt_d;
        end
    end

    // Flatten the list onto the output buses, block 0 in the LSBs.
    always_comb begin
        sack_left  = '0;
        sack_right = '0;
        for (int i = 0; i < int'(SACK_BLOCKS); i++) begin
            sack_left[32*i +: 32]  = left_q[i];
            sack_right[32*i +: 32] = right_q[i];
        end
    end

    assign sack_cnt = cnt_q;
`else
    assign mrg_hit    = 1'b0;
    assign mrg_right  = '0;
    assign sack_left  = '0;
    assign sack_right = '0;
    assign sack_cnt   = '0;
`endif

endmodule

// File: tb/tb_qnigma_tcp_ack_track.sv
// tb_qnigma_tcp_ack_track: directed stimulus, queue-based reference model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_qnigma_tcp_ack_track;

    localparam int unsigned NB      = 4;
    localparam int unsigned TIMEOUT = 50;
    localparam int unsigned THRESH  = 2;
    localparam int unsigned WIN     = 65535;
`ifdef QNIGMA_TCP_SACK_EN
    localparam bit SACK = 1'b1;
`else
    localparam bit SACK = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst, tick_ms, ini, seg_val, ack_sent;
    logic [31:0]    ini_ack, seg_seq;
    logic [15:0]    seg_len;
    logic           seg_rdy, send_ack;
    logic [31:0]    loc_ack;
    logic [32*NB-1:0] sack_left, sack_right;
    logic [2:0]     sack_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    qnigma_tcp_ack_track #(
        .SACK_BLOCKS(NB), .ACK_TIMEOUT_MS(TIMEOUT), .ACK_PKT_THRESH(THRESH), .RX_WIN(WIN)
    ) dut (
        .clk(clk), .rst(rst), .tick_ms(tick_ms), .ini(ini), .ini_ack(ini_ack),
        .seg_val(seg_val), .seg_rdy(seg_rdy), .seg_seq(seg_seq), .seg_len(seg_len),
        .loc_ack(loc_ack), .sack_left(sack_left), .sack_right(sack_right),
        .sack_cnt(sack_cnt), .send_ack(send_ack), .ack_sent(ack_sent)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] l; logic [31:0] r; } blk_t;
    localparam int PIdle = 0, PIns = 1, PMrg = 2;

    blk_t        q[$];
    blk_t        pend, b;
    logic [31:0] m_ack, d, e;
    int          m_pkt, m_tmr, npkt, ntmr, m_phase, hit;
    bit          m_send, set;

    function automatic bit after(input logic [31:0] a, input logic [31:0] c);
        logic [31:0] diff;
        diff = a - c;
        return $signed(diff) > 0;
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst || ini) begin
            m_ack = rst ? 32'd0 : ini_ack;
            q.delete();
            m_pkt = 0; m_tmr = 0; m_send = 0; m_phase = PIdle;
        end else begin
            set  = 0;
            npkt = ack_sent ? 0 : m_pkt;
            ntmr = ack_sent ? 0 : m_tmr;
            if (!ack_sent && tick_ms && m_pkt != 0 && m_tmr < int'(TIMEOUT)) ntmr = m_tmr + 1;
            case (m_phase)
                PIdle: begin
                    if (seg_val && seg_len != 0) begin
                        d = seg_seq - m_ack;
                        e = seg_seq + 32'(seg_len);
                        if (d == 0) begin
                            m_ack = e;
                            if (npkt < 15) npkt++;
                            if (SACK) m_phase = PMrg;
                        end else if (!after(e, m_ack)) begin
                            set = 1;
                        end else if (d < WIN) begin
                            set = 1;
                            if (SACK) begin
                                pend.l = seg_seq; pend.r = e; m_phase = PIns;
                            end
                        end
                    end
                end
                PIns: begin
                    hit = -1;
                    foreach (q[i])
                        if (hit < 0 && !after(q[i].l, pend.r) && !after(pend.l, q[i].r)) hit = i;
                    if (hit >= 0) begin
                        b = q[hit];
                        q.delete(hit);
                        if (after(b.l, pend.l)) b.l = pend.l;
                        if (after(pend.r, b.r)) b.r = pend.r;
                        q.push_front(b);
                    end else begin
                        q.push_front(pend);
                        if (q.size() > NB) q.delete(q.size() - 1);
                    end
                    m_phase = PIdle;
                end
                default: begin
                    hit = -1;
                    foreach (q[i]) if (hit < 0 && !after(q[i].l, m_ack)) hit = i;
                    if (hit >= 0) begin
                        b = q[hit];
                        q.delete(hit);
                        if (after(b.r, m_ack)) m_ack = b.r;
                        set = 1;
                    end else begin
                        m_phase = PIdle;
                    end
                end
            endcase
            if (npkt >= int'(THRESH) || ntmr == int'(TIMEOUT)) set = 1;
            m_pkt  = npkt;
            m_tmr  = ntmr;
            m_send = set ? 1'b1 : (ack_sent ? 1'b0 : m_send);
        end
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s[%0d]: got 0x%08h, required 0x%08h at %0t", name, idx, act, exp,
                     $time);
        end
    endtask

    // Every-cycle comparison against the model.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("loc_ack", 0, loc_ack, m_ack);
            chk("sack_cnt", 0, 32'(sack_cnt), 32'(q.size()));
            chk("send_ack", 0, 32'(send_ack), 32'(m_send));
            chk("seg_rdy", 0, 32'(seg_rdy), 32'(m_phase == PIdle));
            for (int i = 0; i < int'(NB); i++) begin
                chk("sack_left", i, sack_left[32*i +: 32], (i < q.size()) ? q[i].l : 32'd0);
                chk("sack_right", i, sack_right[32*i +: 32], (i < q.size()) ? q[i].r : 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ini(input logic [31:0] v);
        ini = 1'b1; ini_ack = v;
        @(negedge clk);
        ini = 1'b0;
    endtask

    task automatic pulse_ack();
        ack_sent = 1'b1;
        @(negedge clk);
        ack_sent = 1'b0;
    endtask

    task automatic send_seg(input logic [31:0] seq, input logic [15:0] len);
        int budget;
        budget = 20;
        while (!seg_rdy && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("seg_rdy_wait", 0, 32'(seg_rdy), 32'd1);
        seg_val = 1'b1; seg_seq = seq; seg_len = len;
        @(negedge clk);
        seg_val = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick_ms = 0; ini = 0; seg_val = 0; ack_sent = 0;
        ini_ack = '0; seg_seq = '0; seg_len = '0;
        repeat (3) @(negedge clk);
        chk("rst_loc_ack", 0, loc_ack, 32'h0);
        chk("rst_sack_cnt", 0, 32'(sack_cnt), 32'd0);
        chk("rst_send_ack", 0, 32'(send_ack), 32'd0);
        chk("rst_seg_rdy", 0, 32'(seg_rdy), 32'd1);
        rst = 1'b0;

        // Packet threshold.
        pulse_ini(32'h1000);
        send_seg(32'h1000, 16'd100);
        idle(2);
        chk("t1_ack1", 0, loc_ack, 32'h1064);
        chk("t1_send_lo", 0, 32'(send_ack), 32'd0);
        send_seg(32'h1064, 16'd100);
        chk("t1_ack2", 0, loc_ack, 32'h10C8);
        chk("t1_send_hi", 0, 32'(send_ack), 32'd1);
        pulse_ack();
        chk("t1_send_clr", 0, 32'(send_ack), 32'd0);

        // Timeout.
        pulse_ini(32'h2000);
        send_seg(32'h2000, 16'd10);
        idle(2);
        repeat (49) begin
            tick_ms = 1'b1; @(negedge clk);
            tick_ms = 1'b0; @(negedge clk);
        end
        chk("t2_send_49", 0, 32'(send_ack), 32'd0);
        tick_ms = 1'b1; @(negedge clk);
        tick_ms = 1'b0;
        chk("t2_send_50", 0, 32'(send_ack), 32'd1);
        pulse_ack();

        // SACK build-up and merge.
        pulse_ini(32'h1000);
        send_seg(32'h1100, 16'h100);
        send_seg(32'h1300, 16'h100);
        idle(2);
        chk("t3_cnt", 0, 32'(sack_cnt), SACK ? 32'd2 : 32'd0);
        chk("t3_left", 0, sack_left[31:0], SACK ? 32'h1300 : 32'h0);
        chk("t3_right", 0, sack_right[31:0], SACK ? 32'h1400 : 32'h0);
        chk("t3_left", 1, sack_left[63:32], SACK ? 32'h1100 : 32'h0);
        chk("t3_right", 1, sack_right[63:32], SACK ? 32'h1200 : 32'h0);
        chk("t3_send", 0, 32'(send_ack), 32'd1);
        pulse_ack();
        send_seg(32'h1000, 16'h100);
        idle(3);
        chk("t3_ack_m1", 0, loc_ack, SACK ? 32'h1200 : 32'h1100);
        chk("t3_cnt_m1", 0, 32'(sack_cnt), SACK ? 32'd1 : 32'd0);
        send_seg(32'h1200, 16'h100);
        chk("t3_rdy_merge", 0, 32'(seg_rdy), SACK ? 32'd0 : 32'd1);
        idle(3);
        chk("t3_ack_m2", 0, loc_ack, SACK ? 32'h1400 : 32'h1100);
        chk("t3_cnt_m2", 0, 32'(sack_cnt), 32'd0);
        chk("t3_send_m2", 0, 32'(send_ack), 32'd1);
        pulse_ack();

        // Sequence wrap.
        pulse_ini(32'hFFFF_FFF0);
        send_seg(32'hFFFF_FFF0, 16'h20);
        idle(2);
        chk("t4_ack", 0, loc_ack, 32'h10);
        send_seg(32'h30, 16'h10);
        idle(2);
        chk("t4_cnt", 0, 32'(sack_cnt), SACK ? 32'd1 : 32'd0);
        chk("t4_left", 0, sack_left[31:0], SACK ? 32'h30 : 32'h0);
        chk("t4_right", 0, sack_right[31:0], SACK ? 32'h40 : 32'h0);
        pulse_ack();

        // List overflow, abutting merge, duplicate, out-of-window.
        pulse_ini(32'h1000);
        for (int k = 0; k < 5; k++) send_seg(32'h1100 + 32'(k) * 32'h200, 16'h10);
        idle(2);
        chk("t5_cnt", 0, 32'(sack_cnt), SACK ? 32'd4 : 32'd0);
        chk("t5_left", 0, sack_left[31:0], SACK ? 32'h1900 : 32'h0);
        chk("t5_left", 3, sack_left[127:96], SACK ? 32'h1300 : 32'h0);
        send_seg(32'h1310, 16'h10);
        idle(2);
        chk("t5_abut_l", 0, sack_left[31:0], SACK ? 32'h1300 : 32'h0);
        chk("t5_abut_r", 0, sack_right[31:0], SACK ? 32'h1320 : 32'h0);
        chk("t5_abut_l", 3, sack_left[127:96], SACK ? 32'h1500 : 32'h0);
        pulse_ack();
        idle(1);
        chk("t5_send_clr", 0, 32'(send_ack), 32'd0);
        send_seg(32'h0F00, 16'h10);
        chk("t5_dup_send", 0, 32'(send_ack), 32'd1);
        chk("t5_dup_ack", 0, loc_ack, 32'h1000);
        chk("t5_dup_cnt", 0, 32'(sack_cnt), SACK ? 32'd4 : 32'd0);
        pulse_ack();
        send_seg(32'h0002_1000, 16'h10);
        idle(2);
        chk("t5_win_send", 0, 32'(send_ack), 32'd0);
        chk("t5_win_cnt", 0, 32'(sack_cnt), SACK ? 32'd4 : 32'd0);

        // Reset in the middle of a merge.
        send_seg(32'h1000, 16'h300);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_ack", 0, loc_ack, 32'h0);
        chk("t6_cnt", 0, 32'(sack_cnt), 32'd0);
        chk("t6_rdy", 0, 32'(seg_rdy), 32'd1);
        chk("t6_send", 0, 32'(send_ack), 32'd0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
